// File: rtl/iterative_shifter.sv
// iterative_shifter
//   Multi-cycle shifter for the ALU shift path. It performs SLL, SRL, SRA and
//   ROL by a variable amount, moving up to STEP bit positions per clock. Both
//   the request side and the result side use valid/ready handshakes.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start_valid  request valid
//   start_ready  block can accept a request (high only in IDLE)
//   op           00 SLL, 01 SRL, 10 SRA, 11 ROL
//   data_in      operand, sampled at accept only
//   shamt        shift amount 0..WIDTH-1, sampled at accept only
//   result       working register; meaningful while result_valid=1
//   result_valid result complete and held stable until result_ready
//   result_ready consumer accepts result
//   busy         high in SHIFT or DONE
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // STEP may equal WIDTH, which needs one bit more than a shift amount.
  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(STEP);

  state_e             state, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   work, work_d;
  logic [SHAMT_W-1:0] remaining, remaining_d;

  logic [SHAMT_W:0]   rem_wide;
  logic [SHAMT_W:0]   k_wide;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   shifted;

  // Bits moved this cycle: min(STEP, remaining). Because remaining never
  // exceeds WIDTH-1, the result always fits in SHAMT_W bits.
  assign rem_wide = {1'b0, remaining};
  assign k_wide   = (rem_wide < STEP_C) ? rem_wide : STEP_C;
  assign k        = k_wide[SHAMT_W-1:0];

  always_comb begin
    shifted = work;
    unique case (op_q)
      OP_SLL: shifted = work << k;
      OP_SRL: shifted = work >> k;
      // The MSB of work still holds the original sign bit, so an arithmetic
      // shift of the partial result replicates the correct fill.
      OP_SRA: shifted = $signed(work) >>> k;
      // A shift by WIDTH yields zero, so k=0 degenerates cleanly.
      OP_ROL: shifted = (work << k) | (work >> (WIDTH - int'(k)));
      default: shifted = work;
    endcase
  end

  // Next-state and datapath logic.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    op_d        = op_q;
    work_d      = work;
    remaining_d = remaining;
    unique case (state)
      IDLE: begin
        if (start_valid) begin
          op_d        = op_e'(op);
          work_d      = data_in;
          remaining_d = shamt;
          state_d     = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d      = shifted;
        remaining_d = remaining - k;
        if (remaining == k) state_d = DONE;
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_SLL;
      work      <= '0;
      remaining <= '0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      work      <= work_d;
      remaining <= remaining_d;
    end
  end

  assign result       = work;
  assign result_valid = (state == DONE);
  assign start_ready  = (state == IDLE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter
//   Directed bench for iterative_shifter: a STEP=1 instance for the bulk of the
//   operations and a STEP=4 instance for multi-bit stepping. Expected results
//   and latencies are hand-computed constants.
module tb_iterative_shifter;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;

  logic          sv1, sr1, rv1, rr1, busy1;
  logic [1:0]    op1;
  logic [W-1:0]  din1, res1;
  logic [SW-1:0] sh1;

  logic          sv4, sr4, rv4, rr4, busy4;
  logic [1:0]    op4;
  logic [W-1:0]  din4, res4;
  logic [SW-1:0] sh4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(W), .SHAMT_W(SW), .STEP(1)) dut (
    .clk(clk), .rst(rst),
    .start_valid(sv1), .start_ready(sr1), .op(op1), .data_in(din1), .shamt(sh1),
    .result(res1), .result_valid(rv1), .result_ready(rr1), .busy(busy1)
  );

  iterative_shifter #(.WIDTH(W), .SHAMT_W(SW), .STEP(4)) dut4 (
    .clk(clk), .rst(rst),
    .start_valid(sv4), .start_ready(sr4), .op(op4), .data_in(din4), .shamt(sh4),
    .result(res4), .result_valid(rv4), .result_ready(rr4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the selected instance, measure edges from accept to
  // result_valid, check the result, then complete the output handshake.
  task automatic run(input bit use4, input string tag, input logic [1:0] o,
                     input logic [31:0] d, input logic [4:0] s,
                     input logic [31:0] exp_res, input int exp_lat);
    int n;
    if (use4) begin sv4 = 1'b1; op4 = o; din4 = d; sh4 = s; end
    else      begin sv1 = 1'b1; op1 = o; din1 = d; sh1 = s; end
    tick();
    // Scramble the request inputs; they must have no effect after accept.
    if (use4) begin sv4 = 1'b0; op4 = ~o; din4 = ~d; sh4 = ~s; end
    else      begin sv1 = 1'b0; op1 = ~o; din1 = ~d; sh1 = ~s; end
    check({tag, " busy after accept"}, 32'(use4 ? busy4 : busy1), 32'd1);
    n = 0;
    while (!(use4 ? rv4 : rv1) && n < 64) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, use4 ? res4 : res1, exp_res);
    if (use4) rr4 = 1'b1; else rr1 = 1'b1;
    tick();
    if (use4) rr4 = 1'b0; else rr1 = 1'b0;
    check({tag, " back to idle"}, 32'({use4 ? rv4 : rv1, use4 ? busy4 : busy1, use4 ? sr4 : sr1}),
          32'b001);
  endtask

  initial begin
    rst = 1'b1;
    sv1 = 1'b0; rr1 = 1'b0; op1 = 2'b00; din1 = '0; sh1 = '0;
    sv4 = 1'b0; rr4 = 1'b0; op4 = 2'b00; din4 = '0; sh4 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("reset result", res1, 32'h0);
    check("reset flags {result_valid,busy,start_ready}", 32'({rv1, busy1, sr1}), 32'b001);

    // Full-range single-bit stepping.
    run(1'b0, "sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 31);

    // Right shifts with the sign bit set.
    run(1'b0, "sra4", 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F, 4);
    run(1'b0, "srl4", 2'b01, 32'h8000_00F0, 5'd4, 32'h0800_000F, 4);

    // Zero shift: DONE is entered on the accept edge itself.
    run(1'b0, "zero", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 0);

    // Rotates.
    run(1'b0, "rol1", 2'b11, 32'h8000_0001, 5'd1, 32'h0000_0003, 1);
    run(1'b0, "rol4", 2'b11, 32'h8000_0001, 5'd4, 32'h0000_0018, 4);

    // Backpressure: hold DONE for 5 cycles while start_valid pulses.
    sv1 = 1'b1; op1 = 2'b00; din1 = 32'h0000_0005; sh1 = 5'd2;
    tick();
    sv1 = 1'b0;
    tick();
    tick();
    check("bp enters done", 32'(rv1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      sv1 = i[0]; op1 = 2'b01; din1 = 32'hFFFF_0000; sh1 = 5'd0;
      tick();
      check("bp held {result_valid,start_ready}", 32'({rv1, sr1}), 32'b10);
      check("bp held result", res1, 32'h0000_0014);
    end
    // Handshake and a new request in the same cycle: the request must wait.
    sv1 = 1'b1; op1 = 2'b00; din1 = 32'h0000_1234; sh1 = 5'd0;
    rr1 = 1'b1;
    tick();
    rr1 = 1'b0;
    check("same-cycle request ignored {result_valid,busy,start_ready}",
          32'({rv1, busy1, sr1}), 32'b001);
    tick();
    sv1 = 1'b0;
    check("next-cycle request accepted", 32'(rv1), 32'd1);
    check("next-cycle request result", res1, 32'h0000_1234);
    rr1 = 1'b1;
    tick();
    rr1 = 1'b0;

    // Reset in the middle of a 20-bit shift.
    sv1 = 1'b1; op1 = 2'b00; din1 = 32'h0000_0001; sh1 = 5'd20;
    tick();
    sv1 = 1'b0;
    tick();
    tick();
    tick();
    check("mid-op still busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-op reset flags {result_valid,busy,start_ready}", 32'({rv1, busy1, sr1}), 32'b001);
    check("mid-op reset result", res1, 32'h0);
    run(1'b0, "after reset sll2", 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 2);

    // STEP=4 instance: steps of 4,4,1.
    run(1'b1, "step4 srl9", 2'b01, 32'hFFFF_FFFF, 5'd9, 32'h007F_FFFF, 3);
    run(1'b1, "step4 rol8", 2'b11, 32'h1234_5678, 5'd8, 32'h3456_7812, 2);
    run(1'b1, "step4 sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8);
    run(1'b1, "step4 sll3", 2'b00, 32'h0000_0003, 5'd3, 32'h0000_0018, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
